// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Responder for the core's imem/dmem request interfaces. One
//               shared word array serves both ports; each port returns data
//               through a LATENCY-deep response pipeline (LATENCY in 1..8).
//               Optional build macro MEM_RESPONDER_ERR_CHECK_EN enables
//               out-of-range / misalignment error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
   parameter int          LATENCY     = 1,
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h1eceb000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   output logic        imem_err,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        dmem_err
);

   localparam int c_idx_w = $clog2(DEPTH_WORDS);

   // Backing store; deliberately never reset so preloaded contents survive rst.
   logic [31:0] r_mem [DEPTH_WORDS];

   logic [31:0]        w_i_off, w_d_off;
   logic [c_idx_w-1:0] w_i_idx, w_d_idx;
   logic               w_i_req, w_d_req, w_d_wen;
   logic               w_i_err, w_d_err;
   logic [31:0]        w_i_rd, w_d_rd;

   // Byte offset from the window base; word index is the offset modulo depth.
   assign w_i_off = imem_addr - BASE_ADDR;
   assign w_d_off = dmem_addr - BASE_ADDR;
   assign w_i_idx = w_i_off[c_idx_w+1:2];
   assign w_d_idx = w_d_off[c_idx_w+1:2];

   assign w_i_req = |imem_rmask;
   assign w_d_req = (|dmem_rmask) | (|dmem_wmask);

   // Low offset bits never select a word.
   logic w_unused_lo;
   assign w_unused_lo = ^{w_i_off[1:0], w_d_off[1:0]};

`ifdef MEM_RESPONDER_ERR_CHECK_EN
   // Offset beyond the window (unsigned, so below-base also lands here) or
   // a misaligned byte address flags the request.
   assign w_i_err = (w_i_off[31:c_idx_w+2] != '0) || (imem_addr[1:0] != 2'b00);
   assign w_d_err = (w_d_off[31:c_idx_w+2] != '0) || (dmem_addr[1:0] != 2'b00);
`else
   // Addresses simply wrap; upper offset bits are don't-care.
   logic w_unused_hi;
   assign w_unused_hi = ^{w_i_off[31:c_idx_w+2], w_d_off[31:c_idx_w+2],
                          imem_addr[1:0], dmem_addr[1:0]};
   assign w_i_err = 1'b0;
   assign w_d_err = 1'b0;
`endif

   // Erroring requests return zero data and never touch the array.
   assign w_i_rd  = w_i_err ? 32'h0 : r_mem[w_i_idx];
   assign w_d_rd  = w_d_err ? 32'h0 : r_mem[w_d_idx];
   assign w_d_wen = (|dmem_wmask) & ~w_d_err;

   // Byte-lane store; same-edge readers sample the pre-write word.
   always_ff @(posedge clk) begin
      if (w_d_wen) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem_wmask[b]) begin
               r_mem[w_d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
         end
      end
   end

   logic        r_i_vld [LATENCY];
   logic [31:0] r_i_dat [LATENCY];
   logic        r_i_err [LATENCY];
   logic        r_d_vld [LATENCY];
   logic [31:0] r_d_dat [LATENCY];
   logic        r_d_err [LATENCY];

   // Fetch response pipeline; data only advances behind a valid so the
   // output word holds between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) begin
            r_i_vld[s] <= 1'b0;
            r_i_dat[s] <= 32'h0;
            r_i_err[s] <= 1'b0;
         end
      end else begin
         r_i_vld[0] <= w_i_req;
         if (w_i_req) begin
            r_i_dat[0] <= w_i_rd;
            r_i_err[0] <= w_i_err;
         end
         for (int s = 1; s < LATENCY; s++) begin
            r_i_vld[s] <= r_i_vld[s-1];
            if (r_i_vld[s-1]) begin
               r_i_dat[s] <= r_i_dat[s-1];
               r_i_err[s] <= r_i_err[s-1];
            end
         end
      end
   end

   // Data response pipeline; same structure as the fetch side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) begin
            r_d_vld[s] <= 1'b0;
            r_d_dat[s] <= 32'h0;
            r_d_err[s] <= 1'b0;
         end
      end else begin
         r_d_vld[0] <= w_d_req;
         if (w_d_req) begin
            r_d_dat[0] <= w_d_rd;
            r_d_err[0] <= w_d_err;
         end
         for (int s = 1; s < LATENCY; s++) begin
            r_d_vld[s] <= r_d_vld[s-1];
            if (r_d_vld[s-1]) begin
               r_d_dat[s] <= r_d_dat[s-1];
               r_d_err[s] <= r_d_err[s-1];
            end
         end
      end
   end

   assign imem_resp  = r_i_vld[LATENCY-1];
   assign imem_rdata = r_i_dat[LATENCY-1];
   assign imem_err   = r_i_vld[LATENCY-1] & r_i_err[LATENCY-1];
   assign dmem_resp  = r_d_vld[LATENCY-1];
   assign dmem_rdata = r_d_dat[LATENCY-1];
   assign dmem_err   = r_d_vld[LATENCY-1] & r_d_err[LATENCY-1];

endmodule
`default_nettype wire
